// File: rtl/debug_snapshot_buffer.sv
// debug_snapshot_buffer: circular history of stepped-pipeline snapshots with a PC breakpoint,
// post-trigger capture window and a registered field-read port for the debug UART.
module debug_snapshot_buffer #(
   parameter int ADDR_LENGTH          = 11,
   parameter int LONGITUD_INSTRUCCION = 32,
   parameter int CANT_BITS_REGISTROS  = 32,
   parameter int CANT_BITS_CTRL_WORD  = 16,
   parameter int PROFUNDIDAD          = 16,
   parameter int POST_TRIGGER         = 4,
   parameter int CANT_BITS_CAMPO      = 4
) (
   input  logic                              i_clock,
   input  logic                              i_soft_reset,
   input  logic                              i_capture,
   input  logic [ADDR_LENGTH-1:0]            i_pc,
   input  logic [LONGITUD_INSTRUCCION-1:0]   i_instruction,
   input  logic [ADDR_LENGTH-1:0]            i_contador_ciclos,
   input  logic [CANT_BITS_REGISTROS-1:0]    i_data_A,
   input  logic [CANT_BITS_REGISTROS-1:0]    i_data_B,
   input  logic [CANT_BITS_REGISTROS-1:0]    i_extension,
   input  logic [CANT_BITS_CTRL_WORD-1:0]    i_control_word,
   input  logic                              i_break_enable,
   input  logic [ADDR_LENGTH-1:0]            i_break_pc,
   input  logic                              i_freeze,
   input  logic                              i_resume,
   input  logic                              i_rd_req,
   input  logic [$clog2(PROFUNDIDAD)-1:0]    i_rd_idx,
   input  logic [CANT_BITS_CAMPO-1:0]        i_rd_campo,
   output logic [CANT_BITS_REGISTROS-1:0]    o_dato,
   output logic                              o_dato_valid,
   output logic [$clog2(PROFUNDIDAD):0]      o_count,
   output logic                              o_overflow,
   output logic                              o_frozen,
   output logic                              o_triggered
);
   localparam int IW = $clog2(PROFUNDIDAD);
   localparam logic [IW-1:0] POST_LAST = IW'(POST_TRIGGER == 0 ? 0 : POST_TRIGGER - 1);
   localparam logic [IW:0] FULL = (IW+1)'(PROFUNDIDAD);

   typedef enum logic [1:0] {CAPTURA, POST, CONGELADO} state_t;

   typedef struct packed {
      logic [ADDR_LENGTH-1:0]          pc;
      logic [LONGITUD_INSTRUCCION-1:0] instruction;
      logic [ADDR_LENGTH-1:0]          ciclos;
      logic [CANT_BITS_REGISTROS-1:0]  data_a;
      logic [CANT_BITS_REGISTROS-1:0]  data_b;
      logic [CANT_BITS_REGISTROS-1:0]  extension;
      logic [CANT_BITS_CTRL_WORD-1:0]  control_word;
      logic [31:0]                     seq;
   } snap_t;

   state_t                         state_q, state_d;
   logic [IW-1:0]                  wr_ptr_q, wr_ptr_d, post_cnt_q, post_cnt_d, rd_ptr;
   logic [IW:0]                    count_q, count_d;
   logic [31:0]                    seq_q, seq_d;
   logic                           overflow_q, overflow_d, triggered_q, triggered_d;
   logic [CANT_BITS_REGISTROS-1:0] dato_q, dato_d, field;
   logic                           dato_valid_q, dato_valid_d;
   logic                           capture, hit, rd_hit;
   snap_t                          mem [PROFUNDIDAD];
   snap_t                          wr_snap, rd_snap;

   // resume and freeze both swallow a same-cycle capture
   assign capture = i_capture && state_q != CONGELADO && !i_freeze && !i_resume;
   assign hit     = capture && state_q == CAPTURA && i_break_enable && i_pc == i_break_pc;

   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) state_q <= CAPTURA;
      else               state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (i_resume)      state_d = CAPTURA;
      else if (i_freeze) state_d = CONGELADO;
      else if (hit)      state_d = POST_TRIGGER == 0 ? CONGELADO : POST;
      else if (state_q == POST && capture && post_cnt_q == POST_LAST) state_d = CONGELADO;
   end

   always_comb begin
      o_frozen     = state_q == CONGELADO;
      o_count      = count_q;
      o_overflow   = overflow_q;
      o_triggered  = triggered_q;
      o_dato       = dato_q;
      o_dato_valid = dato_valid_q;
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      seq_d       = seq_q;
      overflow_d  = overflow_q;
      triggered_d = triggered_q;
      post_cnt_d  = post_cnt_q;
      if (i_resume) begin
         wr_ptr_d    = '0;
         count_d     = '0;
         seq_d       = '0;
         overflow_d  = 1'b0;
         triggered_d = 1'b0;
         post_cnt_d  = '0;
      end else if (capture) begin
         wr_ptr_d    = wr_ptr_q + 1'b1;
         count_d     = count_q == FULL ? count_q : count_q + 1'b1;
         seq_d       = seq_q + 32'd1;
         overflow_d  = overflow_q | (count_q == FULL);
         triggered_d = triggered_q | hit;
         post_cnt_d  = hit ? '0 : post_cnt_q + 1'b1;
      end
   end

   assign wr_snap = '{pc: i_pc, instruction: i_instruction, ciclos: i_contador_ciclos,
                      data_a: i_data_A, data_b: i_data_B, extension: i_extension,
                      control_word: i_control_word, seq: seq_d};

   always_ff @(posedge i_clock) begin
      if (capture) mem[wr_ptr_q] <= wr_snap;
   end

   // reads see the buffer as it was before this edge's capture
   assign rd_ptr  = wr_ptr_q - IW'(1) - i_rd_idx;
   assign rd_snap = mem[rd_ptr];
   assign rd_hit  = {1'b0, i_rd_idx} < count_q && i_rd_campo <= CANT_BITS_CAMPO'(7);

   always_comb begin
      field = '0;
      case (i_rd_campo[2:0])
         3'd0:    field = CANT_BITS_REGISTROS'(rd_snap.pc);
         3'd1:    field = CANT_BITS_REGISTROS'(rd_snap.instruction);
         3'd2:    field = CANT_BITS_REGISTROS'(rd_snap.ciclos);
         3'd3:    field = rd_snap.data_a;
         3'd4:    field = rd_snap.data_b;
         3'd5:    field = rd_snap.extension;
         3'd6:    field = CANT_BITS_REGISTROS'(rd_snap.control_word);
         default: field = CANT_BITS_REGISTROS'(rd_snap.seq);
      endcase
      dato_d       = i_rd_req ? (rd_hit ? field : '0) : dato_q;
      dato_valid_d = i_rd_req;
   end

   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         wr_ptr_q     <= '0;
         count_q      <= '0;
         seq_q        <= '0;
         overflow_q   <= 1'b0;
         triggered_q  <= 1'b0;
         post_cnt_q   <= '0;
         dato_q       <= '0;
         dato_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         seq_q        <= seq_d;
         overflow_q   <= overflow_d;
         triggered_q  <= triggered_d;
         post_cnt_q   <= post_cnt_d;
         dato_q       <= dato_d;
         dato_valid_q <= dato_valid_d;
      end
   end
endmodule

// File: tb/tb_debug_snapshot_buffer.sv
// tb_debug_snapshot_buffer: random and directed stimulus against a queue-based history model;
// read responses are scoreboarded by a monitor independent of the stimulus process.
module tb_debug_snapshot_buffer;
   localparam int AL = 11, LI = 32, RB = 32, CW = 16, P = 16, PT = 4, CB = 4, IW = $clog2(P);

   typedef logic [7:0][31:0] snap_t;

   logic clk = 0, rst_n = 1;
   logic i_capture = 0, i_break_enable = 0, i_freeze = 0, i_resume = 0, i_rd_req = 0;
   logic [AL-1:0] i_pc = 0, i_contador_ciclos = 0, i_break_pc = 0;
   logic [LI-1:0] i_instruction = 0;
   logic [RB-1:0] i_data_A = 0, i_data_B = 0, i_extension = 0;
   logic [CW-1:0] i_control_word = 0;
   logic [IW-1:0] i_rd_idx = 0;
   logic [CB-1:0] i_rd_campo = 0;
   logic [RB-1:0] o_dato;
   logic o_dato_valid, o_overflow, o_frozen, o_triggered;
   logic [IW:0] o_count;

   snap_t hist[$];
   logic [31:0] expq[$];
   logic [31:0] seq = 0, last_dato = 0;
   int mode = 0, left = 0, exp_count = 0, total = 0, bad = 0;
   bit ovf = 0, trg = 0, exp_ovf = 0, exp_frz = 0, exp_trg = 0, exp_valid = 0;

   debug_snapshot_buffer #(.ADDR_LENGTH(AL), .LONGITUD_INSTRUCCION(LI), .CANT_BITS_REGISTROS(RB),
      .CANT_BITS_CTRL_WORD(CW), .PROFUNDIDAD(P), .POST_TRIGGER(PT), .CANT_BITS_CAMPO(CB)) dut (
      .i_clock(clk), .i_soft_reset(rst_n), .i_capture(i_capture), .i_pc(i_pc),
      .i_instruction(i_instruction), .i_contador_ciclos(i_contador_ciclos), .i_data_A(i_data_A),
      .i_data_B(i_data_B), .i_extension(i_extension), .i_control_word(i_control_word),
      .i_break_enable(i_break_enable), .i_break_pc(i_break_pc), .i_freeze(i_freeze),
      .i_resume(i_resume), .i_rd_req(i_rd_req), .i_rd_idx(i_rd_idx), .i_rd_campo(i_rd_campo),
      .o_dato(o_dato), .o_dato_valid(o_dato_valid), .o_count(o_count), .o_overflow(o_overflow),
      .o_frozen(o_frozen), .o_triggered(o_triggered));

   always #5 clk = ~clk;

   function automatic logic [31:0] model_read(input int idx, input int campo);
      if (idx < hist.size() && campo <= 7) return hist[hist.size() - 1 - idx][campo];
      return 32'd0;
   endfunction

   task automatic publish();
      exp_count = hist.size();
      exp_ovf   = ovf;
      exp_trg   = trg;
      exp_frz   = mode == 2;
   endtask

   task automatic step(input bit cap, input int pc, input bit frz, input bit res, input bit rd,
                       input int idx, input int campo);
      snap_t s;
      i_capture = cap; i_pc = pc[AL-1:0]; i_freeze = frz; i_resume = res;
      i_instruction = $urandom; i_contador_ciclos = AL'($urandom); i_data_A = $urandom;
      i_data_B = $urandom; i_extension = $urandom; i_control_word = CW'($urandom);
      i_rd_req = rd; i_rd_idx = idx[IW-1:0]; i_rd_campo = campo[CB-1:0];
      if (rd) expq.push_back(model_read(idx, campo));
      if (res) begin
         hist.delete(); seq = 0; ovf = 0; trg = 0; mode = 0;
      end else if (frz) mode = 2;
      else if (cap && mode != 2) begin
         seq++;
         s[0] = 32'(i_pc); s[1] = i_instruction; s[2] = 32'(i_contador_ciclos); s[3] = i_data_A;
         s[4] = i_data_B; s[5] = i_extension; s[6] = 32'(i_control_word); s[7] = seq;
         if (hist.size() == P) begin ovf = 1; void'(hist.pop_front()); end
         hist.push_back(s);
         if (mode == 0) begin
            if (i_break_enable && i_pc == i_break_pc) begin
               trg = 1; mode = PT == 0 ? 2 : 1; left = PT;
            end
         end else begin
            left--;
            if (left == 0) mode = 2;
         end
      end
      publish();
      exp_valid = rd;
      @(negedge clk);
   endtask

   task automatic cap(input int pc);
      step(1, pc, 0, 0, 0, 0, 0);
   endtask

   task automatic rd(input int idx, input int campo);
      step(0, 0, 0, 0, 1, idx, campo);
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // reset lands mid-cycle, optionally while a read request is outstanding
   task automatic do_reset(input bit with_read);
      i_rd_req = with_read; i_rd_idx = 0; i_rd_campo = 0;
      #2;
      rst_n = 0;
      hist.delete(); expq.delete(); seq = 0; ovf = 0; trg = 0; mode = 0;
      publish();
      exp_valid = 0;
      @(negedge clk);
      i_capture = 0; i_rd_req = 0; i_freeze = 0; i_resume = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) last_dato = 0;
      chk("count", 32'(o_count), 32'(exp_count));
      chk("overflow", 32'(o_overflow), 32'(exp_ovf));
      chk("frozen", 32'(o_frozen), 32'(exp_frz));
      chk("triggered", 32'(o_triggered), 32'(exp_trg));
      chk("dato_valid", 32'(o_dato_valid), 32'(exp_valid));
      if (o_dato_valid && expq.size() != 0) begin
         last_dato = expq.pop_front();
         chk("dato", o_dato, last_dato);
      end else if (!o_dato_valid) chk("dato_hold", o_dato, last_dato);
   end

   initial begin
      #1 rst_n = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      // basic capture and reads, including an age beyond the stored count
      cap(4); cap(8); cap(12);
      rd(0, 0); rd(2, 0); rd(3, 0); rd(1, 7); rd(0, 9);
      // wrap-around with overflow
      step(0, 0, 0, 1, 0, 0, 0);
      for (int i = 1; i <= 20; i++) cap(i * 4);
      rd(0, 7); rd(15, 7); rd(15, 0); rd(7, 3);
      // breakpoint with post-trigger window, later captures ignored
      step(0, 0, 0, 1, 0, 0, 0);
      i_break_enable = 1; i_break_pc = 40;
      for (int pc = 36; pc <= 64; pc += 4) cap(pc);
      cap(40);
      rd(0, 0); rd(4, 0); rd(5, 0); rd(0, 7);
      // freeze wins over capture, resume clears everything
      step(0, 0, 0, 1, 0, 0, 0);
      i_break_enable = 0;
      cap(96);
      step(1, 100, 1, 0, 0, 0, 0);
      rd(0, 0);
      step(1, 104, 1, 1, 0, 0, 0);
      rd(0, 0);
      // read in the same cycle as a capture sees the previous newest
      cap(196);
      step(1, 200, 0, 0, 1, 0, 0);
      rd(0, 0);
      // reset in POST with a read outstanding
      step(0, 0, 0, 1, 0, 0, 0);
      i_break_enable = 1; i_break_pc = 8;
      cap(0); cap(4); cap(8); cap(12); cap(16);
      do_reset(1);
      rd(0, 0);
      cap(20); rd(0, 0);
      // randomized traffic
      i_break_pc = 32;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) i_break_enable = ~i_break_enable;
         if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 1));
         else step($urandom_range(0, 9) < 6, $urandom_range(0, 15) * 4, $urandom_range(0, 39) == 0,
                   $urandom_range(0, 59) == 0, !i_rd_req && $urandom_range(0, 2) == 0,
                   $urandom_range(0, P - 1), $urandom_range(0, 9));
      end
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
